sel_grant_arbiter: RTL and testbench
====================================

Name: sel_grant_arbiter

Overview:
- Grant-side partner of the request select queue.
- Each grant cycle it names one channel (p_arb_val, p_arb_ch) and publishes the set of request IDs the queue may hand back (p_req_id_enb).
- It samples the queue's selection (p_sel_val, p_sel_req_id), issues the selected request downstream, and tracks outstanding IDs and per-channel credits until completions return them.
- Channel choice is round-robin among channels that the queue reports as pending (p_lru_ch).

Parameters:
- CREDITS, 4, maximum outstanding grants per channel; legal 1..15. Counter width is 4 bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- p_lru_ch  in  4  pending-channel mask from the queue; bit c=1 means the queue holds a valid entry for channel c
- p_sel_val  in  1  queue selected an entry for the current grant; combinational response to p_arb_val
- p_sel_req_id  in  4  ID of the selected entry; valid only with p_sel_val
- p_pe  in  1  parity error from the queue
- ch_rdy  in  4  downstream channel c can accept an issue
- cmp_val  in  1  completion strobe
- cmp_ch  in  2  channel of the completing request
- cmp_id  in  4  ID of the completing request
- p_arb_val  out  1  grant valid
- p_arb_ch  out  2  granted channel
- p_req_id_enb  out  16  bit i=1 means ID i is free and selectable; equals ~busy
- issue_val  out  1  registered issue strobe to downstream
- issue_ch  out  2  issued channel
- issue_id  out  4  issued ID
- err  out  1  sticky protocol/parity error
- miss_cnt  out  8  grant-miss counter (see Optional Feature)

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=IDLE, rr_ptr=2'd3, busy=16'h0000, so p_req_id_enb=16'hFFFF.
  - Every credit[c]=CREDITS.
  - p_arb_val=0, p_arb_ch=0, issue_val=0, issue_ch=0, issue_id=0, err=0, miss_cnt=0.
- Eligibility: eligible[c] = p_lru_ch[c] & ch_rdy[c] & (credit[c]!=0) & (busy!=16'hFFFF).
- Selection: first eligible channel scanning rr_ptr+1, rr_ptr+2, rr_ptr+3, rr_ptr, with mod-4 wrap.
- FSM states: IDLE, GNT, ERR.
  - IDLE: if any channel is eligible, register p_arb_val=1 and p_arb_ch=selected channel, then go to GNT. Otherwise stay in IDLE with p_arb_val=0.
  - GNT (p_arb_val=1 for exactly this one cycle): sample p_sel_val.
    - Hit (p_sel_val=1): set busy[p_sel_req_id]; decrement credit[p_arb_ch]; next cycle issue_val=1, issue_ch=p_arb_ch, issue_id=p_sel_req_id.
    - Miss (p_sel_val=0): no credit or busy change; miss_cnt increments.
    - Both cases: rr_ptr<=p_arb_ch, p_arb_val<=0, go to IDLE.
  - Throughput is at most one grant per 2 cycles. Latency from eligible in IDLE (cycle N) to issue_val is N+2.
  - ERR: p_arb_val=0 and issue_val=0 are held. Completions are still processed. Only reset leaves ERR.
- p_pe=1 in any state: go to ERR next cycle and set err=1. p_pe in GNT discards the selection: no busy set, no credit decrement, no issue.
- Completion (cmp_val=1), processed in any state:
  - Clear busy[cmp_id] and increment credit[cmp_ch].
  - cmp_id not busy: set err=1, no busy change.
  - credit[cmp_ch]==CREDITS: saturate and set err=1.
- Simultaneous events:
  - Grant hit and completion on the same channel in one cycle: net credit unchanged.
  - Grant hit and completion on the same ID: set wins, and err=1.
- p_sel_val=1 outside GNT: ignored, err=1.
- err is sticky until reset.
- Reset mid-GNT: the grant is abandoned, all busy bits clear and all credits restore.

Optional Feature:
- Macro: SEL_ARB_MISS_CNT_EN.
- Defined:
  - miss_cnt is an 8-bit saturating counter (holds at 8'hFF) of GNT cycles with p_sel_val=0 and p_pe=0. Reset to 0.
  - ERR state freezes it.
- Undefined: miss_cnt is tied to 8'h00 and no counter flops exist.

Test Plan:
- Single grant: after reset, p_lru_ch=4'b0100, ch_rdy=4'hF, with the queue returning p_sel_val=1 and id=5 in GNT. Required response:
  - p_arb_val=1 and p_arb_ch=2 at N+1.
  - issue_val=1, ch=2, id=5 at N+2.
  - p_req_id_enb=16'hFFDF, credit[2]=3.
- Round-robin: p_lru_ch=4'hF held with all selections hitting and distinct IDs -> p_arb_ch sequence 0,1,2,3,0, each grant 2 cycles apart.
- Credit exhaustion: CREDITS=4, only channel 1 pending, 4 hits with no completions -> p_arb_val stays 0. Then cmp_val with ch=1 and a busy ID -> a grant appears within 2 cycles.
- Miss and ID-full: 16 hits with no completions -> p_req_id_enb=0 and no further grants. A completion of ID 3 -> enb=16'h0008 and grants resume. A GNT with p_sel_val=0 -> no issue, and miss_cnt=1 when the macro is defined.
- Errors: cmp_id for a non-busy ID -> err=1 and grants continue. p_pe=1 during GNT -> no issue, ERR state with p_arb_val=0 until rst low, after which all outputs return to reset values.

Source files
------------

// File: rtl/sel_grant_arbiter.sv
// rtl/sel_grant_arbiter.sv - round-robin grant arbiter with ID/credit tracking for the request select queue
// Optional miss counter enabled by `define SEL_ARB_MISS_CNT_EN.
module sel_grant_arbiter #(
    parameter int CREDITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  p_lru_ch,
    input  logic        p_sel_val,
    input  logic [3:0]  p_sel_req_id,
    input  logic        p_pe,
    input  logic [3:0]  ch_rdy,
    input  logic        cmp_val,
    input  logic [1:0]  cmp_ch,
    input  logic [3:0]  cmp_id,
    output logic        p_arb_val,
    output logic [1:0]  p_arb_ch,
    output logic [15:0] p_req_id_enb,
    output logic        issue_val,
    output logic [1:0]  issue_ch,
    output logic [3:0]  issue_id,
    output logic        err,
    output logic [7:0]  miss_cnt
);
    typedef enum logic [1:0] {IDLE, GNT, ERR} state_t;
    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    state_t      state_q, state_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0] busy_q, busy_d;
    logic [3:0]  credit_q [4];
    logic [3:0]  credit_d [4];
    logic        arb_val_q, arb_val_d;
    logic [1:0]  arb_ch_q, arb_ch_d;
    logic        issue_val_q, issue_val_d;
    logic [1:0]  issue_ch_q, issue_ch_d;
    logic [3:0]  issue_id_q, issue_id_d;
    logic        err_q, err_d;

    logic [3:0]  elig;
    logic        any_elig;
    logic [1:0]  sel_ch;
    logic [1:0]  idx;
    logic        hit;
    logic        dec, inc;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            elig[c] = p_lru_ch[c] & ch_rdy[c] & (credit_q[c] != 4'd0) & (busy_q != 16'hFFFF);
        end
        any_elig = 1'b0;
        sel_ch   = 2'd0;
        idx      = 2'd0;
        // Scan starts one past the last granted channel so it ends up lowest priority.
        for (int k = 1; k <= 4; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                sel_ch   = idx;
            end
        end
    end

    assign hit = (state_q == GNT) & p_sel_val & ~p_pe;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q;
        arb_val_d   = 1'b0;
        arb_ch_d    = arb_ch_q;
        issue_val_d = 1'b0;
        issue_ch_d  = issue_ch_q;
        issue_id_d  = issue_id_q;
        err_d       = err_q;
        dec         = 1'b0;
        inc         = 1'b0;
        for (int c = 0; c < 4; c++) credit_d[c] = credit_q[c];

        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    arb_val_d = 1'b1;
                    arb_ch_d  = sel_ch;
                    state_d   = GNT;
                end
            end
            GNT: begin
                rr_ptr_d = arb_ch_q;
                state_d  = IDLE;
            end
            default: ;
        endcase

        if (p_pe) begin
            state_d   = ERR;
            err_d     = 1'b1;
            arb_val_d = 1'b0;
        end
        if (p_sel_val && state_q != GNT) err_d = 1'b1;

        // Clear before set so a same-ID hit and completion leaves the ID busy.
        if (cmp_val) begin
            if (!busy_q[cmp_id]) err_d = 1'b1;
            busy_d[cmp_id] = 1'b0;
        end
        if (hit) begin
            busy_d[p_sel_req_id] = 1'b1;
            issue_val_d          = 1'b1;
            issue_ch_d           = arb_ch_q;
            issue_id_d           = p_sel_req_id;
            if (cmp_val && cmp_id == p_sel_req_id) err_d = 1'b1;
        end

        for (int c = 0; c < 4; c++) begin
            dec = hit && (arb_ch_q == 2'(c));
            inc = cmp_val && (cmp_ch == 2'(c));
            if (inc && credit_q[c] == CRED_MAX) err_d = 1'b1;
            if (dec && !inc)
                credit_d[c] = credit_q[c] - 4'd1;
            else if (inc && !dec && credit_q[c] != CRED_MAX)
                credit_d[c] = credit_q[c] + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 2'd3;
            busy_q      <= 16'h0000;
            arb_val_q   <= 1'b0;
            arb_ch_q    <= 2'd0;
            issue_val_q <= 1'b0;
            issue_ch_q  <= 2'd0;
            issue_id_q  <= 4'd0;
            err_q       <= 1'b0;
            for (int c = 0; c < 4; c++) credit_q[c] <= CRED_MAX;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            arb_val_q   <= arb_val_d;
            arb_ch_q    <= arb_ch_d;
            issue_val_q <= issue_val_d;
            issue_ch_q  <= issue_ch_d;
            issue_id_q  <= issue_id_d;
            err_q       <= err_d;
            for (int c = 0; c < 4; c++) credit_q[c] <= credit_d[c];
        end
    end

`ifdef SEL_ARB_MISS_CNT_EN
    logic [7:0] miss_cnt_q, miss_cnt_d;
    logic       miss;

    assign miss = (state_q == GNT) & ~p_sel_val & ~p_pe;

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (miss && miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) miss_cnt_q <= 8'h00;
        else      miss_cnt_q <= miss_cnt_d;
    end

    assign miss_cnt = miss_cnt_q;
`else
    assign miss_cnt = 8'h00;
`endif

    assign p_arb_val    = arb_val_q;
    assign p_arb_ch     = arb_ch_q;
    assign p_req_id_enb = ~busy_q;
    assign issue_val    = issue_val_q;
    assign issue_ch     = issue_ch_q;
    assign issue_id     = issue_id_q;
    assign err          = err_q;

endmodule

// File: tb/tb_sel_grant_arbiter.sv
// tb/tb_sel_grant_arbiter.sv - directed self-checking bench for sel_grant_arbiter
module tb_sel_grant_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  p_lru_ch;
    logic        p_sel_val;
    logic [3:0]  p_sel_req_id;
    logic        p_pe;
    logic [3:0]  ch_rdy;
    logic        cmp_val;
    logic [1:0]  cmp_ch;
    logic [3:0]  cmp_id;
    logic        p_arb_val;
    logic [1:0]  p_arb_ch;
    logic [15:0] p_req_id_enb;
    logic        issue_val;
    logic [1:0]  issue_ch;
    logic [3:0]  issue_id;
    logic        err;
    logic [7:0]  miss_cnt;

    logic        q_hit;
    logic        q_force;
    logic [3:0]  q_id;
    int          total = 0;
    int          bad   = 0;

    // Queue model: answers a grant combinationally.
    assign p_sel_val    = (p_arb_val & q_hit) | q_force;
    assign p_sel_req_id = q_id;

    always #5 clk = ~clk;

    sel_grant_arbiter #(.CREDITS(4)) dut (
        .clk(clk), .rst(rst), .p_lru_ch(p_lru_ch), .p_sel_val(p_sel_val),
        .p_sel_req_id(p_sel_req_id), .p_pe(p_pe), .ch_rdy(ch_rdy),
        .cmp_val(cmp_val), .cmp_ch(cmp_ch), .cmp_id(cmp_id),
        .p_arb_val(p_arb_val), .p_arb_ch(p_arb_ch), .p_req_id_enb(p_req_id_enb),
        .issue_val(issue_val), .issue_ch(issue_ch), .issue_id(issue_id),
        .err(err), .miss_cnt(miss_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0; p_lru_ch = 4'h0; p_pe = 1'b0; ch_rdy = 4'hF;
        cmp_val = 1'b0; cmp_ch = 2'd0; cmp_id = 4'd0;
        q_hit = 1'b0; q_force = 1'b0; q_id = 4'd0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut();
        total++;
        if ({p_arb_val, p_arb_ch, issue_val, issue_ch, issue_id, err, miss_cnt} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs got arb=%b ch=%0d iv=%b ich=%0d iid=%0d err=%b miss=%0d want all 0",
                     p_arb_val, p_arb_ch, issue_val, issue_ch, issue_id, err, miss_cnt);
        end
        total++;
        if (p_req_id_enb !== 16'hFFFF) begin
            bad++; $display("FAIL reset_enb got %h want ffff", p_req_id_enb);
        end
    endtask

    task automatic test_single_grant();
        reset_dut();
        p_lru_ch = 4'b0100; q_hit = 1'b1; q_id = 4'd5;
        tick();
        total++;
        if (p_arb_val !== 1'b1 || p_arb_ch !== 2'd2) begin
            bad++; $display("FAIL single_grant got val=%b ch=%0d want 1 2", p_arb_val, p_arb_ch);
        end
        p_lru_ch = 4'h0;
        tick();
        total++;
        if (issue_val !== 1'b1 || issue_ch !== 2'd2 || issue_id !== 4'd5 || p_arb_val !== 1'b0) begin
            bad++; $display("FAIL single_issue got iv=%b ch=%0d id=%0d arb=%b want 1 2 5 0",
                            issue_val, issue_ch, issue_id, p_arb_val);
        end
        total++;
        if (p_req_id_enb !== 16'hFFDF || dut.credit_q[2] !== 4'd3) begin
            bad++; $display("FAIL single_state got enb=%h cred=%0d want ffdf 3", p_req_id_enb, dut.credit_q[2]);
        end
        cmp_val = 1'b1; cmp_ch = 2'd2; cmp_id = 4'd5;
        tick();
        cmp_val = 1'b0;
        total++;
        if (p_req_id_enb !== 16'hFFFF || err !== 1'b0 || issue_val !== 1'b0) begin
            bad++; $display("FAIL single_cmp got enb=%h err=%b iv=%b want ffff 0 0", p_req_id_enb, err, issue_val);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch [5];
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        reset_dut();
        p_lru_ch = 4'hF; q_hit = 1'b1;
        for (int k = 0; k < 5; k++) begin
            q_id = 4'(k);
            tick();
            total++;
            if (p_arb_val !== 1'b1 || p_arb_ch !== exp_ch[k]) begin
                bad++; $display("FAIL rr_grant%0d got val=%b ch=%0d want 1 %0d", k, p_arb_val, p_arb_ch, exp_ch[k]);
            end
            tick();
            total++;
            if (p_arb_val !== 1'b0 || issue_val !== 1'b1 || issue_id !== 4'(k) || issue_ch !== exp_ch[k]) begin
                bad++; $display("FAIL rr_issue%0d got arb=%b iv=%b id=%0d ch=%0d want 0 1 %0d %0d",
                                k, p_arb_val, issue_val, issue_id, issue_ch, k, exp_ch[k]);
            end
        end
        p_lru_ch = 4'h0;
    endtask

    task automatic test_credit_exhaust();
        int seen;
        reset_dut();
        p_lru_ch = 4'b0010; q_hit = 1'b1;
        for (int k = 0; k < 4; k++) begin
            q_id = 4'(k);
            tick();
            tick();
        end
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (p_arb_val) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL credit_block got grants=%0d want 0", seen);
        end
        q_id = 4'd4;
        cmp_val = 1'b1; cmp_ch = 2'd1; cmp_id = 4'd2;
        tick();
        cmp_val = 1'b0;
        tick();
        total++;
        if (p_arb_val !== 1'b1 || p_arb_ch !== 2'd1 || err !== 1'b0) begin
            bad++; $display("FAIL credit_resume got val=%b ch=%0d err=%b want 1 1 0", p_arb_val, p_arb_ch, err);
        end
        p_lru_ch = 4'h0;
        tick();
    endtask

    task automatic test_id_full_miss();
        reset_dut();
        p_lru_ch = 4'hF; q_hit = 1'b1;
        for (int k = 0; k < 16; k++) begin
            q_id = 4'(k);
            tick();
            tick();
        end
        tick();
        total++;
        if (p_req_id_enb !== 16'h0000 || p_arb_val !== 1'b0) begin
            bad++; $display("FAIL id_full got enb=%h arb=%b want 0000 0", p_req_id_enb, p_arb_val);
        end
        q_hit = 1'b0;
        cmp_val = 1'b1; cmp_ch = 2'd3; cmp_id = 4'd3;
        tick();
        cmp_val = 1'b0;
        total++;
        if (p_req_id_enb !== 16'h0008 || p_arb_val !== 1'b0) begin
            bad++; $display("FAIL id_free got enb=%h arb=%b want 0008 0", p_req_id_enb, p_arb_val);
        end
        tick();
        total++;
        if (p_arb_val !== 1'b1 || p_arb_ch !== 2'd3) begin
            bad++; $display("FAIL id_resume got val=%b ch=%0d want 1 3", p_arb_val, p_arb_ch);
        end
        p_lru_ch = 4'h0;
        tick();
        total++;
        if (issue_val !== 1'b0 || p_req_id_enb !== 16'h0008) begin
            bad++; $display("FAIL miss_issue got iv=%b enb=%h want 0 0008", issue_val, p_req_id_enb);
        end
        total++;
`ifdef SEL_ARB_MISS_CNT_EN
        if (miss_cnt !== 8'd1) begin
            bad++; $display("FAIL miss_cnt got %0d want 1", miss_cnt);
        end
`else
        if (miss_cnt !== 8'd0) begin
            bad++; $display("FAIL miss_cnt got %0d want 0", miss_cnt);
        end
`endif
    endtask

    task automatic test_sel_outside();
        reset_dut();
        q_force = 1'b1; q_id = 4'd6;
        tick();
        q_force = 1'b0;
        total++;
        if (err !== 1'b1 || issue_val !== 1'b0 || p_req_id_enb !== 16'hFFFF) begin
            bad++; $display("FAIL sel_outside got err=%b iv=%b enb=%h want 1 0 ffff", err, issue_val, p_req_id_enb);
        end
    endtask

    task automatic test_errors();
        int seen;
        reset_dut();
        cmp_val = 1'b1; cmp_ch = 2'd0; cmp_id = 4'd7;
        tick();
        cmp_val = 1'b0;
        total++;
        if (err !== 1'b1) begin
            bad++; $display("FAIL cmp_not_busy got err=%b want 1", err);
        end
        p_lru_ch = 4'b0001; q_hit = 1'b1; q_id = 4'd9;
        tick();
        total++;
        if (p_arb_val !== 1'b1 || p_arb_ch !== 2'd0) begin
            bad++; $display("FAIL err_grant got val=%b ch=%0d want 1 0", p_arb_val, p_arb_ch);
        end
        tick();
        total++;
        if (issue_val !== 1'b1 || issue_id !== 4'd9) begin
            bad++; $display("FAIL err_issue got iv=%b id=%0d want 1 9", issue_val, issue_id);
        end
        q_id = 4'd10;
        tick();
        p_pe = 1'b1;
        tick();
        p_pe = 1'b0;
        total++;
        if (issue_val !== 1'b0 || p_arb_val !== 1'b0 || p_req_id_enb !== 16'hFDFF) begin
            bad++; $display("FAIL pe_gnt got iv=%b arb=%b enb=%h want 0 0 fdff", issue_val, p_arb_val, p_req_id_enb);
        end
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (p_arb_val || issue_val) seen++;
        end
        total++;
        if (seen != 0 || err !== 1'b1) begin
            bad++; $display("FAIL err_hold got activity=%0d err=%b want 0 1", seen, err);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({p_arb_val, p_arb_ch, issue_val, issue_ch, issue_id, err, miss_cnt} !== 19'd0
            || p_req_id_enb !== 16'hFFFF) begin
            bad++; $display("FAIL err_reset got arb=%b iv=%b err=%b enb=%h want 0 0 0 ffff",
                            p_arb_val, issue_val, err, p_req_id_enb);
        end
        rst = 1'b1;
        p_lru_ch = 4'h0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_credit_exhaust();
        test_id_full_miss();
        test_sel_outside();
        test_errors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
